// File: rtl/memory_master_if.sv
// Memory-side request/response bus between memory_master and the memory.
// The master drives a one-cycle request strobe; the slave answers with a ready strobe.
interface memory_master_if;
    logic        memory_valid;
    logic        memory_instr;
    logic [31:0] memory_addr;
    logic [31:0] memory_wdata;
    logic [3:0]  memory_wstrb;
    logic [31:0] memory_rdata;
    logic        memory_ready;

    modport master (
        output memory_valid,
        output memory_instr,
        output memory_addr,
        output memory_wdata,
        output memory_wstrb,
        input  memory_rdata,
        input  memory_ready
    );

    modport slave (
        input  memory_valid,
        input  memory_instr,
        input  memory_addr,
        input  memory_wdata,
        input  memory_wstrb,
        output memory_rdata,
        output memory_ready
    );
endinterface

// File: rtl/memory_master.sv
// Arbitrates a fetch port and a data port onto one memory bus, one transaction at a time,
// with round-robin tie-breaking and a per-transaction response timeout.
module memory_master #(
    parameter int unsigned timeout_cycles = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        error,
    memory_master_if.master mem
);

    // Last WAIT count before abort, clamped to the 16-bit saturating counter range.
    localparam logic [15:0] TimeoutLast =
        (timeout_cycles > 32'd65536) ? 16'hFFFF :
        (timeout_cycles == 32'd0)    ? 16'd0    : 16'(timeout_cycles - 32'd1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e      state_q, state_d;
    logic        instr_q, instr_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        last_data_q, last_data_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] irdata_q, irdata_d;
    logic [31:0] drdata_q, drdata_d;
    logic        sel_data;

    // On a tie, grant whichever port did not win last time.
    assign sel_data = dmem_valid & (~imem_valid | ~last_data_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            instr_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            last_data_q <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            irdata_q    <= '0;
            drdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            last_data_q <= last_data_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            irdata_q    <= irdata_d;
            drdata_q    <= drdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        last_data_d = last_data_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        irdata_d    = irdata_q;
        drdata_d    = drdata_q;
        unique case (state_q)
            StIdle: begin
                if (imem_valid || dmem_valid) begin
                    state_d = StIssue;
                    instr_d = ~sel_data;
                    addr_d  = sel_data ? dmem_addr  : imem_addr;
                    wdata_d = sel_data ? dmem_wdata : 32'd0;
                    wstrb_d = sel_data ? dmem_wstrb : 4'd0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (mem.memory_ready) begin
                    state_d = StDone;
                    if (instr_q) irdata_d = mem.memory_rdata;
                    else         drdata_d = mem.memory_rdata;
                end else if (cnt_q >= TimeoutLast) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                    if (instr_q) irdata_d = '0;
                    else         drdata_d = '0;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDone: begin
                state_d     = StIdle;
                last_data_d = ~instr_q;
                cnt_d       = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    assign mem.memory_valid = (state_q == StIssue);
    assign mem.memory_instr = instr_q;
    assign mem.memory_addr  = addr_q;
    assign mem.memory_wdata = wdata_q;
    assign mem.memory_wstrb = wstrb_q;

    assign imem_ready = (state_q == StDone) & instr_q;
    assign dmem_ready = (state_q == StDone) & ~instr_q;
    assign error      = (state_q == StDone) & err_q;
    assign imem_rdata = irdata_q;
    assign dmem_rdata = drdata_q;

endmodule

// File: doc/memory_master.md
MEMORY_MASTER -- requirements
Module: memory_master

Interface
REQ-001 Parameter: timeout_cycles, default 1024, WAIT-state cycles without memory_ready before a transaction is aborted.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 imem_valid  input  1  fetch request; held with imem_addr until imem_ready.
REQ-005 imem_addr  input  32  fetch address.
REQ-006 imem_rdata  output  32  fetch data, valid with imem_ready.
REQ-007 imem_ready  output  1  one-cycle fetch completion pulse.
REQ-008 dmem_valid  input  1  data request; held with addr/wdata/wstrb until dmem_ready.
REQ-009 dmem_addr  input  32  data address.
REQ-010 dmem_wdata  input  32  store data.
REQ-011 dmem_wstrb  input  4  byte strobes; 0 means load.
REQ-012 dmem_rdata  output  32  load data, valid with dmem_ready.
REQ-013 dmem_ready  output  1  one-cycle data completion pulse.
REQ-014 error  output  1  pulses with imem_ready or dmem_ready when that transaction timed out.
REQ-015 memory_valid  output  1  one-cycle request strobe to memory.
REQ-016 memory_instr  output  1  1 for fetch, 0 for data.
REQ-017 memory_addr  output  32  request address.
REQ-018 memory_wdata  output  32  request write data.
REQ-019 memory_wstrb  output  4  request byte strobes.
REQ-020 memory_rdata  input  32  response data, sampled when memory_ready is 1.
REQ-021 memory_ready  input  1  response strobe.

Function
REQ-022 States: IDLE, ISSUE, WAIT, DONE; one transaction outstanding at most.
REQ-023 IDLE: no valid -> stay; any valid -> register grant, addr, wdata, wstrb, instr flag; go ISSUE.
REQ-024 Arbitration: one requester -> grant it; both -> grant the port not granted last; last-grant resets to fetch, so data wins first tie after reset.
REQ-025 Fetch grant: memory_wstrb=0, memory_wdata=0, memory_instr=1; data grant: dmem fields passed unchanged, memory_instr=0.
REQ-026 ISSUE: memory_valid=1 exactly one cycle with registered fields; go WAIT; memory_ready in ISSUE ignored.
REQ-027 memory_valid SHALL be 0 in IDLE, WAIT, DONE; never asserted twice per transaction.
REQ-028 memory_addr/wdata/wstrb/instr SHALL hold stable from ISSUE through DONE.
REQ-029 WAIT: memory_ready=1 -> capture memory_rdata into granted port rdata, go DONE; else increment 16-bit saturating timeout counter.
REQ-030 WAIT: counter reaches timeout_cycles-1 with memory_ready=0 -> rdata=0, set error, go DONE.
REQ-031 DONE: granted port ready=1 for exactly one cycle, error per REQ-030, update last-grant, clear counter, go IDLE.
REQ-032 Latency without contention: request in IDLE at cycle N, memory_valid at N+1, memory_ready at N+2, port ready at N+3; next request may issue at N+4.
REQ-033 Non-granted port ready SHALL stay 0; its rdata holds its last value.
REQ-034 imem_ready and dmem_ready SHALL never be 1 in the same cycle.
REQ-035 memory_ready in IDLE or DONE SHALL be ignored, no state change.
REQ-036 Requests deasserted before completion are protocol violations; behaviour unspecified, no deadlock allowed.

Reset
REQ-037 rst=0 SHALL immediately force IDLE, outputs 0, counter 0, last-grant=fetch, error=0.
REQ-038 Reset mid-transaction abandons it; no ready pulse for it after release; late memory_ready ignored per REQ-035.
REQ-039 First request may be accepted on the first rising edge with rst=1.

Verification
REQ-040 Fetch 0x00000100, memory returns 0x00000013 one cycle after strobe -> memory_valid=1 one cycle, memory_instr=1, wstrb=0; imem_ready at N+3, imem_rdata=0x00000013, error=0.
REQ-041 Store 0x00001000, wdata 0x00000001, wstrb 0xF -> memory_instr=0, addr/wdata/wstrb passed; dmem_ready pulse, no imem_ready.
REQ-042 Fetch and data valid same cycle after reset -> data served first, fetch next, strobes four cycles apart, one ready each.
REQ-043 Memory never responds, timeout_cycles=8 -> after 8 WAIT cycles, ready pulse with error=1, rdata=0; next request normal.
REQ-044 rst low during WAIT, memory_ready arrives after release -> outputs 0, no ready pulse, state IDLE.
REQ-045 Byte store wstrb=0x2 then load same word -> only byte-1 strobe sent; load rdata equals memory_rdata word.
